pkt_ingress_framer: RTL and testbench
=====================================

# pkt_ingress_framer

Upstream stage of the packet processor. Accepts a raw valid/ready word stream with an end-of-packet flag and stages one complete packet in an internal buffer so its length is known. It then replays the packet into the processor's enqueue port, presenting `in_sop`, `pck_len_valid` and `pck_len_i` with the first word and `in_eop` with the last. It honours the processor's full and almost-full backpressure and drops oversize packets.

## Interface
- `DATA_W`, 32, word width; equals processor `wr_data_i` width
- `LEN_W`, 12, width of `pck_len_i`; length is in words
- `BUF_DEPTH`, 64, staging buffer depth in words = max packet length (power of 2, ≤ 2^LEN_W−1)

Clocking and reset (already decided): one clock, `pck_proc_int_mem_fsm_clk`; reset is synchronous and active-high, `pck_proc_int_mem_fsm_sw_rst`.

- `pck_proc_int_mem_fsm_clk`  in  1  clock; all logic on posedge
- `pck_proc_int_mem_fsm_sw_rst`  in  1  synchronous active-high reset
- `s_valid`  in  1  upstream word valid
- `s_ready`  out  1  framer accepts a word this cycle
- `s_data`  in  DATA_W  upstream word
- `s_last`  in  1  word is last of packet
- `pck_proc_full`  in  1  processor full
- `pck_proc_almost_full`  in  1  processor almost full
- `enq_req`  out  1  enqueue strobe, one word per asserted cycle
- `in_sop`  out  1  first word of packet
- `in_eop`  out  1  last word of packet
- `wr_data_i`  out  DATA_W  enqueued word
- `pck_len_valid`  out  1  `pck_len_i` valid; asserted only together with `in_sop`
- `pck_len_i`  out  LEN_W  packet length in words, 1..BUF_DEPTH
- `drop_cnt`  out  8  oversize-packet drop count, saturating

## Operation
- FSM states: COLLECT, DROP, WAIT_SPACE, SEND. Reset state is COLLECT.
- COLLECT:
  - `s_ready`=1. On a beat (`s_valid&&s_ready`), write `s_data` to `buf[wcnt]` and increment `wcnt`.
  - Beat with `s_last`: set `len = wcnt+1`, go to WAIT_SPACE.
  - Beat without `s_last` when `wcnt == BUF_DEPTH−1`: the packet exceeds the buffer. Go to DROP and increment `drop_cnt`.
- DROP: `s_ready`=1. Discard beats. The beat with `s_last` returns the FSM to COLLECT with `wcnt=0`.
- WAIT_SPACE: `s_ready`=0. When `!pck_proc_almost_full && !pck_proc_full`, go to SEND with `rcnt=0`.
- SEND: `s_ready`=0.
  - Each cycle with `!pck_proc_full`: drive `enq_req`=1, `wr_data_i=buf[rcnt]`, `in_sop=(rcnt==0)`, `pck_len_valid=(rcnt==0)`, `pck_len_i=len`, `in_eop=(rcnt==len−1)`; increment `rcnt`.
  - While `pck_proc_full`=1: `enq_req`, `in_sop`, `in_eop` and `pck_len_valid` are 0, and `rcnt` holds.
  - After the `in_eop` word: clear `wcnt` and go to COLLECT.
- One packet is staged at a time; there is no overlap of collect and send.
- Sideband rules:
  - `in_sop`, `in_eop` and `pck_len_valid` are never high without `enq_req`.
  - A 1-word packet asserts `in_sop` and `in_eop` in the same cycle with `pck_len_i`=1.
- Reset values: `s_ready`=0 in the reset cycle, then 1. `enq_req`, `in_sop`, `in_eop`, `pck_len_valid`=0; `wr_data_i`, `pck_len_i`=0; `drop_cnt`=0. `wcnt`, `rcnt`, `len` are cleared. Buffer contents are don't-care.
- Reset mid-operation: the FSM returns to COLLECT within the same edge and any partially collected or partially sent packet is abandoned. The processor shares the reset, so a missing `in_eop` is not an error.
- `drop_cnt` saturates at 255.

## Timing
- All outputs except `s_ready` are registered; `s_ready` is decoded from the state register.
- Latency: `s_last` beat accepted at edge t → WAIT_SPACE at t+1 → earliest SEND at t+2, with the first `enq_req` visible after edge t+2.
- An N-word packet with no backpressure occupies N consecutive `enq_req` cycles.
- `pck_proc_almost_full` is sampled only in WAIT_SPACE. Mid-packet, only `pck_proc_full` stalls, and the stall takes effect in the same cycle: the output register is not loaded, so `enq_req` is 0 that cycle.
- `s_valid` may drop mid-packet; `wcnt` holds.

## Configuration
- `PKT_ING_DROP_CNT_EN`:
  - Defined: `drop_cnt` counter is implemented as specified.
  - Undefined: no counter register; `drop_cnt` is tied to 0. Oversize packets are still dropped identically.

## Test plan
- 4-word packet `A0..A3`, processor idle → `enq_req` high 4 consecutive cycles starting 2 cycles after the last beat. `in_sop`+`pck_len_valid`, `pck_len_i`=4 on `A0`; `in_eop` on `A3`.
- 1-word packet `0xDEADBEEF` → single `enq_req` cycle with `in_sop`=`in_eop`=`pck_len_valid`=1 and `pck_len_i`=1.
- 70-word packet, `BUF_DEPTH`=64 → no `enq_req`, all 70 beats accepted, `drop_cnt`=1. A following 3-word packet is sent with `pck_len_i`=3.
- Hold `pck_proc_almost_full`=1 for 10 cycles after an 8-word packet is collected → `enq_req` stays 0 and `s_ready`=0. Release → 8 words sent in order.
- `pck_proc_full`=1 for 3 cycles after word 2 of a 6-word packet → `enq_req`=0 for those 3 cycles. Words 3–5 follow with no duplicate or skip, and `in_eop` on word 5.
- Assert `pck_proc_int_mem_fsm_sw_rst` during word 3 of SEND → next cycle all outputs 0 and `drop_cnt`=0. `s_ready`=1 the cycle after reset deasserts, and a new 2-word packet transfers correctly.

Source files
------------

// File: rtl/pkt_ingress_framer.sv
// pkt_ingress_framer: stages one whole packet so its length is known, then replays it into
// the packet processor's enqueue port with sop/eop/length sideband.
// Optional feature macro: PKT_ING_DROP_CNT_EN (oversize drop counter; tied to 0 when undefined).
`timescale 1ns/1ps
module pkt_ingress_framer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned BUF_DEPTH = 64
) (
  input  logic              pck_proc_int_mem_fsm_clk,
  input  logic              pck_proc_int_mem_fsm_sw_rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              pck_proc_full,
  input  logic              pck_proc_almost_full,
  output logic              enq_req,
  output logic              in_sop,
  output logic              in_eop,
  output logic [DATA_W-1:0] wr_data_i,
  output logic              pck_len_valid,
  output logic [LEN_W-1:0]  pck_len_i,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {StCollect, StDrop, StWaitSpace, StSend} state_e;

  state_e              r_state, w_state_nxt;
  logic [AW-1:0]       r_wcnt, w_wcnt_nxt;
  logic [AW-1:0]       r_rcnt, w_rcnt_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic                r_enq, w_enq_nxt;
  logic                r_sop, w_sop_nxt;
  logic                r_eop, w_eop_nxt;
  logic                r_lenv, w_lenv_nxt;
  logic [DATA_W-1:0]   r_wr_data, w_wr_data_nxt;
  logic [LEN_W-1:0]    r_pck_len, w_pck_len_nxt;
  logic [DATA_W-1:0]   r_buf [BUF_DEPTH];

  logic                w_beat;
  logic                w_buf_we;
  logic                w_drop_inc;
  logic                w_is_last;
  logic [DATA_W-1:0]   w_rd_word;

  // Gated by reset so the reset cycle never advertises readiness.
  assign s_ready   = ((r_state == StCollect) || (r_state == StDrop)) &&
                     !pck_proc_int_mem_fsm_sw_rst;
  assign w_beat    = s_valid && s_ready;
  assign w_rd_word = r_buf[r_rcnt];
  assign w_is_last = (LEN_W'(r_rcnt) == (r_len - LEN_W'(1)));

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_rcnt_nxt    = r_rcnt;
    w_len_nxt     = r_len;
    w_enq_nxt     = 1'b0;
    w_sop_nxt     = 1'b0;
    w_eop_nxt     = 1'b0;
    w_lenv_nxt    = 1'b0;
    w_wr_data_nxt = r_wr_data;
    w_pck_len_nxt = r_pck_len;
    w_buf_we      = 1'b0;
    w_drop_inc    = 1'b0;
    unique case (r_state)
      StCollect: begin
        if (w_beat) begin
          w_buf_we   = 1'b1;
          w_wcnt_nxt = r_wcnt + AW'(1);
          if (s_last) begin
            w_len_nxt   = LEN_W'(r_wcnt) + LEN_W'(1);
            w_state_nxt = StWaitSpace;
          end else if (r_wcnt == AW'(BUF_DEPTH - 1)) begin
            // Packet is longer than the buffer: discard the rest of it.
            w_state_nxt = StDrop;
            w_drop_inc  = 1'b1;
            w_wcnt_nxt  = '0;
          end
        end
      end
      StDrop: begin
        if (w_beat && s_last) begin
          w_state_nxt = StCollect;
          w_wcnt_nxt  = '0;
        end
      end
      StWaitSpace: begin
        if (!pck_proc_almost_full && !pck_proc_full) begin
          w_state_nxt = StSend;
          w_rcnt_nxt  = '0;
        end
      end
      StSend: begin
        // Full stalls in the same cycle: output register not loaded, rcnt holds.
        if (!pck_proc_full) begin
          w_enq_nxt     = 1'b1;
          w_wr_data_nxt = w_rd_word;
          w_sop_nxt     = (r_rcnt == '0);
          w_lenv_nxt    = (r_rcnt == '0);
          w_pck_len_nxt = r_len;
          w_eop_nxt     = w_is_last;
          w_rcnt_nxt    = r_rcnt + AW'(1);
          if (w_is_last) begin
            w_state_nxt = StCollect;
            w_wcnt_nxt  = '0;
          end
        end
      end
      default: w_state_nxt = StCollect;
    endcase
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (pck_proc_int_mem_fsm_sw_rst) begin
      r_state   <= StCollect;
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_len     <= '0;
      r_enq     <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_lenv    <= 1'b0;
      r_wr_data <= '0;
      r_pck_len <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_len     <= w_len_nxt;
      r_enq     <= w_enq_nxt;
      r_sop     <= w_sop_nxt;
      r_eop     <= w_eop_nxt;
      r_lenv    <= w_lenv_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_pck_len <= w_pck_len_nxt;
    end
  end

  // Staging buffer write; contents need no reset.
  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (w_buf_we) begin
      r_buf[r_wcnt] <= s_data;
    end
  end

  assign enq_req       = r_enq;
  assign in_sop        = r_sop;
  assign in_eop        = r_eop;
  assign pck_len_valid = r_lenv;
  assign wr_data_i     = r_wr_data;
  assign pck_len_i     = r_pck_len;

`ifdef PKT_ING_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of oversize packets.
  always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
    if (pck_proc_int_mem_fsm_sw_rst) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop_inc;
  assign w_unused_drop_inc = w_drop_inc;
  assign drop_cnt          = 8'd0;
`endif

endmodule

// File: tb/tb_pkt_ingress_framer.sv
// Randomized bench for pkt_ingress_framer with a packet-level scoreboard.
`timescale 1ns/1ps
module tb_pkt_ingress_framer;

  localparam int unsigned DataW    = 32;
  localparam int unsigned LenW     = 12;
  localparam int unsigned BufDepth = 64;
`ifdef PKT_ING_DROP_CNT_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DataW-1:0] s_data = '0;
  logic             s_last = 1'b0;
  logic             full = 1'b0;
  logic             afull = 1'b0;
  logic             enq_req, in_sop, in_eop, pck_len_valid;
  logic [DataW-1:0] wr_data;
  logic [LenW-1:0]  pck_len;
  logic [7:0]       drop_cnt;

  pkt_ingress_framer #(
    .DATA_W   (DataW),
    .LEN_W    (LenW),
    .BUF_DEPTH(BufDepth)
  ) u_dut (
    .pck_proc_int_mem_fsm_clk   (clk),
    .pck_proc_int_mem_fsm_sw_rst(rst),
    .s_valid                    (s_valid),
    .s_ready                    (s_ready),
    .s_data                     (s_data),
    .s_last                     (s_last),
    .pck_proc_full              (full),
    .pck_proc_almost_full       (afull),
    .enq_req                    (enq_req),
    .in_sop                     (in_sop),
    .in_eop                     (in_eop),
    .wr_data_i                  (wr_data),
    .pck_len_valid              (pck_len_valid),
    .pck_len_i                  (pck_len),
    .drop_cnt                   (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DataW-1:0] data;
    logic             sop;
    logic             eop;
    logic [LenW-1:0]  len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   drops = 0;
  bit   bp_stop = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_drop();
    if (!DropEn) return 0;
    return (drops > 255) ? 255 : drops;
  endfunction

  // Scoreboard: every enqueued word must be the next expected word of an in-limit packet.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("side_wo_enq", 64'({in_sop, in_eop, pck_len_valid} & {3{~enq_req}}), 64'd0);
      if (enq_req === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_val("unexp_enq", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("wr_data", 64'(wr_data), 64'(mon_e.data));
          check_val("in_sop", 64'(in_sop), 64'(mon_e.sop));
          check_val("pck_len_valid", 64'(pck_len_valid), 64'(mon_e.sop));
          check_val("in_eop", 64'(in_eop), 64'(mon_e.eop));
          check_val("pck_len_i", 64'(pck_len), 64'(mon_e.len));
        end
      end
    end
  end

  // Drive one packet; returns just after the edge that accepts the last beat.
  task automatic push_pkt(input int n, input bit fixed, input logic [DataW-1:0] base,
                          input bit gaps);
    logic [DataW-1:0] words[$];
    logic [DataW-1:0] d;
    exp_t e;
    int t;
    for (int i = 0; i < n; i++) begin
      d = fixed ? (base + DataW'(i)) : DataW'($urandom);
      if (gaps && ($urandom_range(3) == 0)) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (i == n - 1);
      t = 0;
      while (!s_ready && t < 5000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 5000) begin
        check_val("s_ready_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      words.push_back(d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (n <= BufDepth) begin
      for (int i = 0; i < n; i++) begin
        e.data = words[i];
        e.sop  = (i == 0);
        e.eop  = (i == n - 1);
        e.len  = LenW'(n);
        exp_q.push_back(e);
      end
    end else begin
      drops++;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Count enqueued words (at negedges) until n have been seen.
  task automatic wait_enq(input int n);
    int c = 0;
    int t = 0;
    while (c < n && t < 200) begin
      @(negedge clk);
      if (enq_req === 1'b1) c++;
      t++;
    end
    if (t >= 200) check_val("enq_timeout", 64'(c), 64'(n));
  endtask

  task automatic bp_proc();
    while (!bp_stop) begin
      @(negedge clk);
      full  = ($urandom_range(4) == 0);
      afull = ($urandom_range(3) == 0);
    end
    full  = 1'b0;
    afull = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_s_ready", 64'(s_ready), 64'd0);
    check_val("rst_enq", 64'({enq_req, in_sop, in_eop, pck_len_valid}), 64'd0);
    check_val("rst_wr_data", 64'(wr_data), 64'd0);
    check_val("rst_pck_len", 64'(pck_len), 64'd0);
    check_val("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_s_ready", 64'(s_ready), 64'd1);

    // 4-word packet: enq_req on edges t+2..t+5 after the last beat edge t.
    push_pkt(4, 1'b1, 32'hA0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_val("pkt4_enq_timing", 64'(enq_req), 64'((i >= 2 && i <= 5) ? 1 : 0));
    end
    wait_drain();

    // 1-word packet.
    push_pkt(1, 1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("pkt1_enq_timing", 64'(enq_req), 64'((i == 2) ? 1 : 0));
    end
    wait_drain();

    // Oversize packet dropped, then a 3-word packet.
    push_pkt(70, 1'b0, '0, 1'b0);
    repeat (5) @(negedge clk);
    check_val("drop_cnt_70", 64'(drop_cnt), 64'(exp_drop()));
    check_val("drop_s_ready", 64'(s_ready), 64'd1);
    push_pkt(3, 1'b0, '0, 1'b0);
    wait_drain();

    // Almost-full holds the packet in staging.
    afull = 1'b1;
    push_pkt(8, 1'b1, 32'h8000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("afull_enq", 64'(enq_req), 64'd0);
      check_val("afull_s_ready", 64'(s_ready), 64'd0);
    end
    afull = 1'b0;
    wait_drain();

    // Full for 3 cycles after word 2 of a 6-word packet.
    push_pkt(6, 1'b1, 32'h6000, 1'b0);
    wait_enq(3);
    full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("full_stall_enq", 64'(enq_req), 64'd0);
    end
    full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("full_resume_enq", 64'(enq_req), 64'((i < 3) ? 1 : 0));
    end
    wait_drain();

    // Reset while word 3 is being sent.
    push_pkt(6, 1'b1, 32'h5000, 1'b0);
    wait_enq(4);
    #1;
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    drops = 0;
    check_val("midrst_flags", 64'({enq_req, in_sop, in_eop, pck_len_valid}), 64'd0);
    check_val("midrst_wr_data", 64'(wr_data), 64'd0);
    check_val("midrst_pck_len", 64'(pck_len), 64'd0);
    check_val("midrst_drop_cnt", 64'(drop_cnt), 64'd0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_s_ready", 64'(s_ready), 64'd1);
    push_pkt(2, 1'b1, 32'h2000, 1'b0);
    wait_drain();

    // Random packets with gaps and random backpressure.
    fork
      bp_proc();
      begin
        for (int p = 0; p < 40; p++) begin
          push_pkt(($urandom_range(7) == 0) ? $urandom_range(65, 80) : $urandom_range(1, 64),
                   1'b0, '0, 1'b1);
        end
        wait_drain();
        bp_stop = 1'b1;
      end
    join
    wait_drain();
    check_val("drop_cnt_random", 64'(drop_cnt), 64'(exp_drop()));

    // Drive the drop counter into saturation.
    for (int p = 0; p < 256; p++) push_pkt(65, 1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("drop_cnt_sat", 64'(drop_cnt), 64'(exp_drop()));
    push_pkt(BufDepth, 1'b0, '0, 1'b0);
    wait_drain();
    check_val("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
